// File: rtl/ctech_lib_clk_gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctech_clk_gate_ctrl_pkg
//   Shared types and sizing helpers for the per-domain clock-gating controller.
//
//   cg_state_e : per-domain gating state
//     CG_RUN   - clock running, domain active (or held on by a wake condition)
//     CG_IDLE  - clock running, counting idle cycles toward the hysteresis limit
//     CG_GATED - clock stopped
//     CG_WAKE  - clock restarted, waiting WAKE_LAT cycles before declaring RUN
//
//   cg_cnt_w() : counter width able to hold both the hysteresis compare value
//                and the wake latency count.
// -----------------------------------------------------------------------------
package ctech_clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_IDLE  = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    // Width of the shared idle/wake counter: max(HYST_W, $clog2(WAKE_LAT+1)).
    function automatic int cg_cnt_w(input int hyst_w, input int wake_lat);
        int lat_w;
        lat_w = $clog2(wake_lat + 1);
        return (hyst_w > lat_w) ? hyst_w : lat_w;
    endfunction

    localparam int CG_HYST_W_DEF   = 8;
    localparam int CG_WAKE_LAT_DEF = 4;
    localparam int CG_CNT_W        = cg_cnt_w(CG_HYST_W_DEF, CG_WAKE_LAT_DEF);

endpackage : ctech_clk_gate_ctrl_pkg

// File: rtl/ctech_lib_clk_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// ctech_lib_clk_gate_ctrl_if
//   Per-domain traffic / wake handshake bundle between the traffic monitors
//   (master) and the clock-gating controller (slave).
//
//   busy      : master -> slave, per-domain activity indicator
//   wake_req  : master -> slave, per-domain wake request
//   force_on  : master -> slave, per-domain software keep-on override
//   wake_ack  : slave -> master, clock running and stable for that domain
//   gated_sts : slave -> master, 1 = domain clock currently gated off
//   dbg_state : slave -> master, per-domain FSM state, 2 bits per domain
//               (domain i at [2*i +: 2], encoding of cg_state_e)
//
//   Handshake: wake_req/wake_ack is a 4-phase pair. The requester raises
//   wake_req and holds it until wake_ack is seen high; the controller raises
//   wake_ack only once the domain is in RUN. The requester then drops
//   wake_req and wake_ack falls after the next clock edge. While wake_req is
//   held the domain is kept in RUN.
// -----------------------------------------------------------------------------
interface ctech_lib_clk_gate_ctrl_if #(
    parameter int N_DOM = 4
);

    logic [N_DOM-1:0]   busy;
    logic [N_DOM-1:0]   wake_req;
    logic [N_DOM-1:0]   force_on;
    logic [N_DOM-1:0]   wake_ack;
    logic [N_DOM-1:0]   gated_sts;
    logic [2*N_DOM-1:0] dbg_state;

    modport master (
        output busy,
        output wake_req,
        output force_on,
        input  wake_ack,
        input  gated_sts,
        input  dbg_state
    );

    modport slave (
        input  busy,
        input  wake_req,
        input  force_on,
        output wake_ack,
        output gated_sts,
        output dbg_state
    );

endinterface : ctech_lib_clk_gate_ctrl_if

// File: rtl/ctech_lib_clk_gate_ctrl_dom_fsm.sv
// -----------------------------------------------------------------------------
// ctech_clk_gate_dom_fsm
//   One domain's idle-hysteresis gating FSM, idle/wake counter and wake
//   acknowledge. All outputs are flops decoded from the next state, so the
//   clock-gate enable has no combinational path from the inputs.
//
//   clk          : in  free-running source clock
//   rst_b        : in  asynchronous active-low reset
//   wake_cond_i  : in  busy | wake_req | force_on | scan_mode for this domain
//   wake_req_i   : in  wake request (qualifies wake_ack)
//   hyst_cfg_i   : in  idle cycles tolerated before gating
//   en_o         : out clock-gate enable (0 only in GATED)
//   gated_sts_o  : out 1 while the domain is GATED
//   wake_ack_o   : out wake_req acknowledged, domain in RUN
//   state_o      : out current FSM state (debug)
// -----------------------------------------------------------------------------
module ctech_clk_gate_dom_fsm
    import ctech_clk_gate_ctrl_pkg::*;
#(
    parameter int HYST_W   = 8,
    parameter int WAKE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              wake_cond_i,
    input  logic              wake_req_i,
    input  logic [HYST_W-1:0] hyst_cfg_i,
    output logic              en_o,
    output logic              gated_sts_o,
    output logic              wake_ack_o,
    output cg_state_e         state_o
);

    localparam int               CNT_W     = cg_cnt_w(HYST_W, WAKE_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LAT - 1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hyst_ext;
    logic             en_q, gated_sts_q, wake_ack_q;

    assign hyst_ext = CNT_W'(hyst_cfg_i);

    // Saturating increment: the counter holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CG_RUN: begin
                if (!wake_cond_i) begin
                    state_d = CG_IDLE;
                    cnt_d   = '0;
                end
            end
            CG_IDLE: begin
                // A wake condition beats an expiring hysteresis count.
                if (wake_cond_i) begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= hyst_ext) begin
                    // >= so that lowering hyst_cfg below the current count
                    // gates at the very next edge.
                    state_d = CG_GATED;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CG_GATED: begin
                if (wake_cond_i) begin
                    state_d = CG_WAKE;
                    cnt_d   = '0;
                end
            end
            CG_WAKE: begin
                // The wake sequence always completes; no abort on a dropped
                // wake condition.
                if (cnt_q == WAKE_LAST) begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = CG_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= CG_RUN;
            cnt_q       <= '0;
            en_q        <= 1'b1;
            gated_sts_q <= 1'b0;
            wake_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= (state_d != CG_GATED);
            gated_sts_q <= (state_d == CG_GATED);
            wake_ack_q  <= wake_req_i & (state_d == CG_RUN);
        end
    end

    assign en_o        = en_q;
    assign gated_sts_o = gated_sts_q;
    assign wake_ack_o  = wake_ack_q;
    assign state_o     = state_q;

endmodule : ctech_clk_gate_dom_fsm

// File: rtl/ctech_lib_clk_gate_te.sv
// -----------------------------------------------------------------------------
// ctech_lib_clk_gate_te
//   Behavioural model of the latch-based integrated clock gate with test
//   enable. The enable is captured by a latch that is transparent while clk is
//   low, so changes on en/te only take effect at the next rising edge and the
//   gated clock never glitches.
//
//   clk    : in  source clock
//   en     : in  functional enable
//   te     : in  test enable (scan), ORed with en
//   clkout : out gated clock
// -----------------------------------------------------------------------------
module ctech_lib_clk_gate_te (
    input  logic clk,
    input  logic en,
    input  logic te,
    output logic clkout
);

    logic en_l;

    always_latch begin
        if (!clk) begin
            en_l <= en | te;
        end
    end

    assign clkout = clk & en_l;

endmodule : ctech_lib_clk_gate_te

// File: rtl/ctech_lib_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// ctech_lib_clk_gate_ctrl
//   Per-domain idle-hysteresis clock-gating controller for N_DOM gated clock
//   domains. Each domain runs an independent FSM that drives the enable of
//   its own ctech_lib_clk_gate_te cell. scan_mode drives te of every gate and
//   also acts as a wake condition so all FSMs settle in RUN during scan;
//   leaving scan restarts the hysteresis from RUN.
//
//   clk        : in   free-running source clock
//   rst_b      : in   asynchronous active-low reset
//   scan_mode  : in   DFT mode, forces all gated clocks on
//   hyst_cfg   : in   idle cycles tolerated before gating (all domains)
//   dom        : slave modport of ctech_lib_clk_gate_ctrl_if
//                (busy, wake_req, force_on in; wake_ack, gated_sts,
//                 dbg_state out)
//   gclk       : out  gated clocks, one per domain
// -----------------------------------------------------------------------------
module ctech_lib_clk_gate_ctrl
    import ctech_clk_gate_ctrl_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int HYST_W   = 8,
    parameter int WAKE_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 scan_mode,
    input  logic [HYST_W-1:0]    hyst_cfg,
    ctech_lib_clk_gate_ctrl_if.slave dom,
    output logic [N_DOM-1:0]     gclk
);

    logic [N_DOM-1:0]   wake_cond;
    logic [N_DOM-1:0]   en;
    logic [N_DOM-1:0]   ack;
    logic [N_DOM-1:0]   sts;
    logic [2*N_DOM-1:0] state_flat;

    assign wake_cond = dom.busy | dom.wake_req | dom.force_on | {N_DOM{scan_mode}};

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        cg_state_e state;

        ctech_clk_gate_dom_fsm #(
            .HYST_W   (HYST_W),
            .WAKE_LAT (WAKE_LAT)
        ) u_fsm (
            .clk         (clk),
            .rst_b       (rst_b),
            .wake_cond_i (wake_cond[i]),
            .wake_req_i  (dom.wake_req[i]),
            .hyst_cfg_i  (hyst_cfg),
            .en_o        (en[i]),
            .gated_sts_o (sts[i]),
            .wake_ack_o  (ack[i]),
            .state_o     (state)
        );

        assign state_flat[2*i +: 2] = state;

        ctech_lib_clk_gate_te u_cg (
            .clk    (clk),
            .en     (en[i]),
            .te     (scan_mode),
            .clkout (gclk[i])
        );
    end

    assign dom.wake_ack  = ack;
    assign dom.gated_sts = sts;
    assign dom.dbg_state = state_flat;

endmodule : ctech_lib_clk_gate_ctrl

// File: tb/tb_ctech_lib_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ctech_lib_clk_gate_ctrl
//   Self-checking bench: directed scenarios followed by a long random run.
//   A per-domain reference model predicts state, gated_sts, wake_ack and the
//   gated clock level for every cycle; predictions go into exp_q when inputs
//   are driven and are compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_ctech_lib_clk_gate_ctrl;
  import ctech_clk_gate_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int HW = 8;
  localparam int WL = 4;
  localparam int W  = 5 * N;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_b;
  logic          scan_mode;
  logic [HW-1:0] hyst_cfg;
  logic [N-1:0]  gclk;

  always #5 clk = ~clk;

  ctech_lib_clk_gate_ctrl_if #(.N_DOM(N)) dif ();

  ctech_lib_clk_gate_ctrl #(
    .N_DOM    (N),
    .HYST_W   (HW),
    .WAKE_LAT (WL)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .scan_mode (scan_mode),
    .hyst_cfg  (hyst_cfg),
    .dom       (dif.slave),
    .gclk      (gclk)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  cg_state_e    m_state[N];
  int           m_cnt[N];
  logic [N-1:0] m_en;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = CG_RUN;
      m_cnt[i]   = 0;
    end
    m_en = '1;
  endtask

  // Predict the outcome of the next clock edge from the inputs now applied.
  task automatic predict();
    logic [N-1:0]   wc;
    logic [N-1:0]   sts;
    logic [N-1:0]   ack;
    logic [N-1:0]   gexp;
    logic [2*N-1:0] st;
    wc   = dif.busy | dif.wake_req | dif.force_on | {N{scan_mode}};
    // The gate latch loads en|te in the low phase before the next rising edge.
    gexp = m_en | {N{scan_mode}};
    for (int i = 0; i < N; i++) begin
      case (m_state[i])
        CG_RUN:   if (!wc[i]) begin m_state[i] = CG_IDLE; m_cnt[i] = 0; end
        CG_IDLE: begin
          if (wc[i]) begin
            m_state[i] = CG_RUN;
            m_cnt[i]   = 0;
          end else if (m_cnt[i] >= int'(hyst_cfg)) begin
            m_state[i] = CG_GATED;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        CG_GATED: if (wc[i]) begin m_state[i] = CG_WAKE; m_cnt[i] = 0; end
        default: begin
          if (m_cnt[i] == WL - 1) begin
            m_state[i] = CG_RUN;
            m_cnt[i]   = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      endcase
      sts[i]        = (m_state[i] == CG_GATED);
      ack[i]        = dif.wake_req[i] && (m_state[i] == CG_RUN);
      st[2*i +: 2]  = m_state[i];
    end
    m_en = ~sts;
    exp_q.push_back({gexp, st, ack, sts});
  endtask

  // ---------------------------------------------------------------- driver
  task automatic cycle();
    logic [W-1:0]   e;
    logic [N-1:0]   run_m;
    logic [2*N-1:0] dbg;
    predict();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("gated_sts", 32'(dif.gated_sts), 32'(e[N-1:0]));
      check("wake_ack",  32'(dif.wake_ack),  32'(e[2*N-1:N]));
      check("state",     32'(dif.dbg_state), 32'(e[4*N-1:2*N]));
      check("gclk",      32'(gclk),          32'(e[5*N-1:4*N]));
    end
    dbg = dif.dbg_state;
    for (int i = 0; i < N; i++) run_m[i] = (dbg[2*i +: 2] == 2'(CG_RUN));
    check("ack_only_in_run", 32'(dif.wake_ack & ~run_m), 32'd0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asynchronous reset applied mid-cycle, clock high.
  task automatic reset_mid();
    rst_b = 1'b0;
    #1;
    check("rst_gated_sts", 32'(dif.gated_sts), 32'd0);
    check("rst_wake_ack",  32'(dif.wake_ack),  32'd0);
    check("rst_state",     32'(dif.dbg_state), 32'd0);
    @(posedge clk);
    #1;
    check("rst_gclk", 32'(gclk), 32'hf);
    rst_b = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_b        = 1'b1;
    scan_mode    = 1'b0;
    hyst_cfg     = 8'd3;
    dif.busy     = '1;
    dif.wake_req = '0;
    dif.force_on = '0;
    model_reset();
    #2 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por_gated_sts", 32'(dif.gated_sts), 32'd0);
    check("por_wake_ack",  32'(dif.wake_ack),  32'd0);
    check("por_gclk",      32'(gclk),          32'hf);
    rst_b = 1'b1;
    run(3);

    // Hysteresis 3: gated after the 5th edge that sees busy low.
    dif.busy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("hyst3_sts0", 32'(dif.gated_sts[0]), 32'(k == 4));
    end
    cycle();
    check("hyst3_gclk0_stopped", 32'(gclk[0]), 32'd0);
    dif.busy[0] = 1'b1;
    run(WL + 1);

    // Busy pulse in IDLE returns to RUN and restarts the count.
    dif.busy[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) dif.busy[0] = 1'b1;
      if (k == 3) dif.busy[0] = 1'b0;
      cycle();
      check("pulse_sts0", 32'(dif.gated_sts[0]), 32'(k == 7));
    end

    // Wake handshake on domain 1.
    dif.busy[1] = 1'b0;
    run(6);
    check("d1_gated", 32'(dif.gated_sts[1]), 32'd1);
    dif.wake_req[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("wake_ack1", 32'(dif.wake_ack[1]), 32'(k >= WL));
      if (k == 1) check("wake_gclk1", 32'(gclk[1]), 32'd1);
    end
    run(3);
    check("wake_hold_run1", 32'(dif.gated_sts[1]), 32'd0);
    dif.wake_req[1] = 1'b0;
    cycle();
    check("ack_drop1", 32'(dif.wake_ack[1]), 32'd0);

    // hyst_cfg = 0: gated one edge after IDLE entry.
    hyst_cfg    = 8'd0;
    dif.busy[0] = 1'b1;
    run(WL + 2);
    dif.busy[0] = 1'b0;
    cycle();
    check("h0_idle_sts0", 32'(dif.gated_sts[0]), 32'd0);
    cycle();
    check("h0_gated_sts0", 32'(dif.gated_sts[0]), 32'd1);

    // Lowering hyst_cfg below the running count gates at the next edge.
    dif.busy[0] = 1'b1;
    run(WL + 2);
    hyst_cfg    = 8'd200;
    dif.busy[0] = 1'b0;
    run(6);
    check("h200_not_gated", 32'(dif.gated_sts[0]), 32'd0);
    hyst_cfg = 8'd2;
    cycle();
    check("hyst_lowered_gated", 32'(dif.gated_sts[0]), 32'd1);

    // Wake condition and expiring count in the same cycle: wake wins.
    dif.busy[0] = 1'b1;
    run(WL + 2);
    hyst_cfg    = 8'd3;
    dif.busy[0] = 1'b0;
    run(4);
    dif.busy[0] = 1'b1;
    cycle();
    check("wake_wins_state0", 32'(dif.dbg_state[1:0]), 32'(CG_RUN));
    check("wake_wins_sts0",   32'(dif.gated_sts[0]),   32'd0);

    // Reset while every domain is gated.
    dif.busy = '0;
    run(10);
    check("pre_rst_all_gated", 32'(dif.gated_sts), 32'hf);
    reset_mid();
    run(2);

    // force_on keeps domain 2 running.
    dif.force_on[2] = 1'b1;
    dif.busy        = '0;
    run(1000);
    check("force_on2_sts", 32'(dif.gated_sts[2]), 32'd0);
    check("force_on_others_gated", 32'(dif.gated_sts), 32'hb);
    dif.force_on = '0;

    // Scan mode: all clocks on, ack follows wake_req; exit resumes gating.
    scan_mode    = 1'b1;
    dif.wake_req = 4'b0101;
    cycle();
    check("scan_gclk", 32'(gclk), 32'hf);
    run(WL + 2);
    check("scan_ack", 32'(dif.wake_ack), 32'h5);
    dif.wake_req = '0;
    scan_mode    = 1'b0;
    run(10);
    check("scan_exit_gated", 32'(dif.gated_sts), 32'hf);

    // Random traffic on all domains.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 199) == 0) hyst_cfg = 8'($urandom_range(0, 6));
      if (scan_mode) scan_mode = ($urandom_range(0, 4) != 0);
      else           scan_mode = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        dif.busy[i] = ($urandom_range(0, 99) < 15);
        if (dif.wake_req[i] && dif.wake_ack[i])  dif.wake_req[i] = 1'b0;
        else if (!dif.wake_req[i])               dif.wake_req[i] = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 299) == 0)         dif.force_on[i] = ~dif.force_on[i];
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ctech_lib_clk_gate_ctrl
